// File: rtl/ndro_bank.sv
`default_nettype none
// ============================================================================
// Module   : ndro_bank
// Purpose  : WIDTH-channel NDRO/DRO storage bank with parallel readout,
//            post-read hold-window and set/clr collision checking.
// Revision : 1.0  initial release
// ============================================================================
module ndro_bank #(
    parameter int WIDTH       = 4,
    parameter int GUARD       = 2,
    parameter int DESTRUCTIVE = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] clr,
    input  logic             read,
    input  logic             viol_clr,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [WIDTH-1:0] viol,
    output logic [CNT_W-1:0] viol_cnt
);

    localparam int               c_guard_w    = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
    localparam logic [c_guard_w-1:0] c_guard_load = c_guard_w'(GUARD);
    localparam logic [CNT_W-1:0] c_cnt_max    = '1;

    logic [WIDTH-1:0]     r_state;
    logic [c_guard_w-1:0] r_guard;

    logic                 w_guard_act;
    logic [WIDTH-1:0]     w_flag;
    logic [WIDTH-1:0]     w_set_ok;
    logic [WIDTH-1:0]     w_clr_ok;
    logic [WIDTH-1:0]     w_base;
    logic [WIDTH-1:0]     w_state_nxt;
    logic                 w_any_flag;

    // Events sharing a cycle with a read land after the sample and are legal.
    assign w_guard_act = (r_guard != '0) && !read;

    always_comb begin
        w_flag      = (set & clr) | ((set | clr) & {WIDTH{w_guard_act}});
        w_set_ok    = set & ~clr & ~{WIDTH{w_guard_act}};
        w_clr_ok    = clr & ~set & ~{WIDTH{w_guard_act}};
        w_base      = (read && (DESTRUCTIVE != 0)) ? '0 : r_state;
        w_state_nxt = (w_base | w_set_ok) & ~w_clr_ok;
        w_any_flag  = |w_flag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= '0;
            r_guard   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            out_valid <= read;
            if (read) begin
                out     <= r_state;
                r_guard <= c_guard_load;
            end else if (r_guard != '0) begin
                r_guard <= r_guard - c_guard_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            viol     <= '0;
            viol_cnt <= '0;
        end else if (viol_clr) begin
            viol     <= w_flag;
            viol_cnt <= w_any_flag ? CNT_W'(1) : '0;
        end else begin
            viol <= viol | w_flag;
            if (w_any_flag && (viol_cnt != c_cnt_max))
                viol_cnt <= viol_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
